// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access widths, load/store FSM states and memory opcodes.
// Also holds the alignment-fault rule used by the load/store stage.
package cpu_pkg;

   typedef enum logic [1:0] {
      WIDTH_BYTE = 2'b00,
      WIDTH_HALF = 2'b01,
      WIDTH_WORD = 2'b10,
      WIDTH_RSVD = 2'b11
   } width_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } mem_state_t;

   typedef enum logic [1:0] {
      LOAD = 2'b00,
      STR  = 2'b01,
      PUSH = 2'b10,
      POP  = 2'b11
   } mem_op_t;

   // A request faults before reaching the bus if misaligned or of reserved width.
   function automatic logic access_faults(input logic [1:0] width, input logic [1:0] addr_lo);
      case (width)
         WIDTH_BYTE: return 1'b0;
         WIDTH_HALF: return addr_lo[0];
         WIDTH_WORD: return (addr_lo != 2'b00);
         default:    return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational.
module mem_lane_align
   import cpu_pkg::*;
(
   input  logic [1:0]  i_width,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_signed,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rd_data,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wr_data,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte      = i_rd_data[7:0];
      w_half      = i_addr_lo[1] ? i_rd_data[31:16] : i_rd_data[15:0];
      o_sel       = 4'b0000;
      o_wr_data   = i_store_data;
      o_load_data = i_rd_data;
      case (i_addr_lo)
         2'b01:   w_byte = i_rd_data[15:8];
         2'b10:   w_byte = i_rd_data[23:16];
         2'b11:   w_byte = i_rd_data[31:24];
         default: w_byte = i_rd_data[7:0];
      endcase
      case (i_width)
         WIDTH_BYTE: begin
            o_sel       = 4'b0001 << i_addr_lo;
            o_wr_data   = {4{i_store_data[7:0]}};
            o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
         end
         WIDTH_HALF: begin
            o_sel       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wr_data   = {2{i_store_data[15:0]}};
            o_load_data = {{16{i_signed & w_half[15]}}, w_half};
         end
         WIDTH_WORD: o_sel = 4'b1111;
         default:    o_sel = 4'b0000;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Load/store stage: one Wishbone pipelined transaction per request, with load write-back.
// Define MEM_TIMEOUT_EN to bound the wait for ack to TIMEOUT_CYCLES cycles.
module mem_access
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_enable,
   input  logic              i_is_store,
   input  logic [1:0]        i_width,
   input  logic              i_signed,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_store_data,
   input  logic [3:0]        i_dest_reg,
   output logic              o_busy,
   output logic              o_completed,
   output logic              o_fault,
   output logic              o_load_we,
   output logic [3:0]        o_load_reg,
   output logic [DATA_W-1:0] o_load_data,
   output logic              o_wb_cyc,
   output logic              o_wb_stb,
   output logic              o_wb_we,
   output logic [ADDR_W-1:0] o_wb_addr,
   output logic [DATA_W-1:0] o_wb_data,
   output logic [3:0]        o_wb_sel,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic              i_wb_ack,
   input  logic              i_wb_stall,
   input  logic              i_wb_err
);

   mem_state_t        r_state, w_next;
   logic              r_is_store, r_signed, r_fault;
   logic [1:0]        r_width;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_store_data, r_load_data;
   logic [3:0]        r_dest;
   logic              w_req_fault, w_bus_done, w_bus_fault, w_timeout;
   logic [3:0]        w_sel;
   logic [31:0]       w_wr_data, w_load_ext;

   mem_lane_align u_align (
      .i_width      (r_width),
      .i_addr_lo    (r_addr[1:0]),
      .i_signed     (r_signed),
      .i_store_data (r_store_data),
      .i_rd_data    (i_wb_data),
      .o_sel        (w_sel),
      .o_wr_data    (w_wr_data),
      .o_load_data  (w_load_ext)
   );

`ifdef MEM_TIMEOUT_EN
   logic [31:0] r_wait_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                r_wait_cnt <= '0;
      else if (r_state == REQ)   r_wait_cnt <= '0;
      else if (r_state == WAIT)  r_wait_cnt <= r_wait_cnt + 32'd1;
   end

   assign w_timeout = (r_state == WAIT) && (r_wait_cnt == TIMEOUT_CYCLES - 32'd1);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Err takes priority over ack; a response in the acceptance cycle ends the transfer.
   always_comb begin
      w_next      = r_state;
      w_bus_done  = 1'b0;
      w_bus_fault = 1'b0;
      w_req_fault = access_faults(i_width, i_addr[1:0]);
      case (r_state)
         IDLE: if (i_enable) w_next = w_req_fault ? DONE : REQ;
         REQ: begin
            if (!i_wb_stall) begin
               if (i_wb_ack || i_wb_err) begin
                  w_next      = DONE;
                  w_bus_done  = 1'b1;
                  w_bus_fault = i_wb_err;
               end else begin
                  w_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (i_wb_ack || i_wb_err) begin
               w_next      = DONE;
               w_bus_done  = 1'b1;
               w_bus_fault = i_wb_err;
            end else if (w_timeout) begin
               w_next      = DONE;
               w_bus_fault = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_is_store   <= 1'b0;
         r_signed     <= 1'b0;
         r_fault      <= 1'b0;
         r_width      <= 2'b00;
         r_addr       <= '0;
         r_store_data <= '0;
         r_dest       <= 4'd0;
         r_load_data  <= '0;
      end else begin
         if (r_state == IDLE && i_enable) begin
            r_is_store   <= i_is_store;
            r_signed     <= i_signed;
            r_width      <= i_width;
            r_addr       <= i_addr;
            r_store_data <= i_store_data;
            r_dest       <= i_dest_reg;
            r_fault      <= w_req_fault;
         end else if ((r_state == REQ || r_state == WAIT) && w_next == DONE) begin
            r_fault <= w_bus_fault;
         end
         if (w_bus_done && !w_bus_fault && !r_is_store) r_load_data <= w_load_ext;
      end
   end

   assign o_busy      = (r_state != IDLE);
   assign o_completed = (r_state == DONE);
   assign o_fault     = (r_state == DONE) && r_fault;
   assign o_load_we   = (r_state == DONE) && !r_fault && !r_is_store;
   assign o_load_reg  = r_dest;
   assign o_load_data = r_load_data;
   assign o_wb_cyc    = (r_state == REQ) || (r_state == WAIT);
   assign o_wb_stb    = (r_state == REQ);
   assign o_wb_we     = o_wb_cyc && r_is_store;
   assign o_wb_addr   = o_wb_cyc ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign o_wb_data   = o_wb_cyc ? w_wr_data : '0;
   assign o_wb_sel    = o_wb_cyc ? w_sel : 4'b0000;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Load/store stage directly downstream of the execute step of the 32-bit CPU.
- Takes one memory request per enable pulse (LOAD/STR/PUSH/POP) and runs a single Wishbone pipelined-mode bus transaction.
- Returns a register write-back (loads) or a completion pulse (stores), which feeds the write-back/commit step that re-enables fetch.
- Supports byte/half/word width, little-endian lane steering, optional sign extension and alignment faulting.

Parameters:
- ADDR_W, 32, width of the address bus.
- DATA_W, 32, width of the data bus; must be 32.
- TIMEOUT_CYCLES, 255, maximum wait for ack after strobe acceptance; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  one-cycle request pulse from execute.
- i_is_store  in  1  1 = store, 0 = load.
- i_width  in  2  00 byte, 01 half, 10 word, 11 reserved (faults).
- i_signed  in  1  sign-extend load result.
- i_addr  in  32  byte address.
- i_store_data  in  32  store value, right-aligned.
- i_dest_reg  in  4  destination register index for a load.
- o_busy  out  1  request in flight.
- o_completed  out  1  one-cycle done pulse.
- o_fault  out  1  valid with o_completed: misaligned/reserved width/bus error/timeout.
- o_load_we  out  1  one-cycle register write strobe.
- o_load_reg  out  4  register index for the load write-back.
- o_load_data  out  32  extended load result.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone control.
- o_wb_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_wb_data  out  32  lane-steered store data.
- o_wb_sel  out  4  byte enables.
- i_wb_data  in  32  read data.
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  Wishbone responses.

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, latched request cleared. Takes effect mid-transaction; cyc/stb drop immediately.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On i_enable, latch all inputs and set o_busy.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or width 11 -> DONE with fault; no bus cycle is issued.
  - Otherwise -> REQ.
- REQ: cyc=stb=1, we=is_store.
  - Hold all bus outputs stable while i_wb_stall=1.
  - When stall=0, the strobe is accepted -> WAIT with stb=0, cyc=1.
  - An ack/err sampled in the acceptance cycle is honoured; go straight to DONE.
- WAIT: cyc=1, stb=0 until i_wb_ack or i_wb_err -> DONE. If ack and err are both high, err wins.
- DONE (one cycle):
  - cyc=0, o_completed=1, o_busy=0 on the next cycle -> IDLE.
  - o_fault set on error.
  - For a successful load: o_load_we=1 and o_load_reg=latched dest.
- Lane steering (little-endian), with k=addr[1:0]:
  - Byte: sel=1<<k; store data replicated to all 4 lanes.
  - Half: sel=0011 or 1100 by addr[1]; store data replicated to both halves.
  - Word: sel=1111.
  - Load extracts lane k (byte) or half addr[1], then zero- or sign-extends per i_signed.
- Latency with no stall and ack in the cycle after acceptance: i_enable at T0, stb at T1, ack at T2, o_completed/o_load_we at T3.
- Faulting requests complete at T1 with o_load_we=0.
- i_enable while o_busy=1 is ignored; it is not queued. i_enable in the DONE cycle is also ignored.
- o_load_data holds its last value between loads. It is undefined-but-stable on a faulted load; o_load_we=0 in that case.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined: a counter clears on strobe acceptance and counts cycles in WAIT. When it reaches TIMEOUT_CYCLES, drop cyc, go to DONE with o_fault=1.
- Undefined: WAIT is unbounded and no counter logic is synthesised.

Decomposition:
- Shared package cpu_pkg holds:
  - width encodings (WIDTH_BYTE/HALF/WORD)
  - FSM state encodings
  - opcode constants shared with decode/execute (LOAD, STR, PUSH, POP)
- One natural sub-module, mem_lane_align: combinational sel/store-data steering and load extraction/extension. The FSM stays in mem_access.

Test Plan:
- Word load: addr 0x00001004, bus returns 0xDEADBEEF, no stall -> sel 1111, o_wb_addr 0x00001004, o_load_we at T3, data 0xDEADBEEF, reg as given.
- Signed byte load: addr 0x00001007 with i_signed=1, bus data 0x80112233 -> sel 1000, o_load_data 0xFFFFFF80; same request with i_signed=0 -> 0x00000080.
- Half store: addr 0x2002, data 0x0000ABCD, stall held 3 cycles -> stb/addr/data stable for 4 cycles, sel 1100, o_wb_data 0xABCDABCD, we=1, o_completed with no o_load_we.
- Misaligned word load at 0x2001 -> no cyc ever asserted, o_completed+o_fault at T1; width 11 behaves the same.
- Bus error plus reset: err in WAIT -> fault, o_load_we=0. Separately, reset pulled low during WAIT -> cyc/stb 0 immediately; after release, a new request completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never arrives -> cyc drops and o_fault=1 exactly 4 cycles after acceptance.
